// File: rtl/led_feedback.sv
// led_feedback: acknowledgement blinker for the pet controller.
// Plays BLINKS on/off pairs on the LED of the accepted action (feed or
// medicate). It keeps at most one pending request per action, and serves
// comida first when both actions are requested at the same time.
//
// Ports:
//   clk          system clock (rising edge)
//   reset        asynchronous, active-high reset
//   test         selects the fast half-period (HALF_PERIOD/TEST_DIV, min 1)
//   ev_comida    single-cycle food event
//   ev_medicina  single-cycle medicine event
//   led_comida   food LED (registered)
//   led_medicina medicine LED (registered)
//   busy         high while a sequence plays (registered)
//   overrun      one-cycle pulse when an event is dropped (registered)
module led_feedback #(
  parameter int unsigned HALF_PERIOD = 12500000,
  parameter int unsigned TEST_DIV    = 1000,
  parameter int unsigned BLINKS      = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic test,
  input  logic ev_comida,
  input  logic ev_medicina,
  output logic led_comida,
  output logic led_medicina,
  output logic busy,
  output logic overrun
);

  localparam int unsigned CW      = $clog2(HALF_PERIOD) + 1;
  localparam int unsigned HP_FAST = ((HALF_PERIOD / TEST_DIV) < 1) ? 1 : (HALF_PERIOD / TEST_DIV);
  localparam int unsigned BW      = $clog2(BLINKS + 1);

  localparam logic [CW-1:0] LAST_NORM  = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] LAST_FAST  = CW'(HP_FAST - 1);
  localparam logic [BW-1:0] LAST_BLINK = BW'(BLINKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_e;
  typedef enum logic {CH_COMIDA, CH_MEDICINA} chan_e;

  state_e        state_q, state_d;
  chan_e         chan_q, chan_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] blk_q, blk_d;
  logic          fast_q, fast_d;
  logic          pend_c_q, pend_c_d;
  logic          pend_m_q, pend_m_d;
  logic          led_c_q, led_c_d;
  logic          led_m_q, led_m_d;
  logic          busy_q, busy_d;
  logic          ovr_q, ovr_d;

  logic phase_last;
  logic decide;
  logic req_c, req_m;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      chan_q   <= CH_COMIDA;
      cnt_q    <= '0;
      blk_q    <= '0;
      fast_q   <= 1'b0;
      pend_c_q <= 1'b0;
      pend_m_q <= 1'b0;
      led_c_q  <= 1'b0;
      led_m_q  <= 1'b0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      chan_q   <= chan_d;
      cnt_q    <= cnt_d;
      blk_q    <= blk_d;
      fast_q   <= fast_d;
      pend_c_q <= pend_c_d;
      pend_m_q <= pend_m_d;
      led_c_q  <= led_c_d;
      led_m_q  <= led_m_d;
      busy_q   <= busy_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    cnt_d    = cnt_q;
    blk_d    = blk_q;
    fast_d   = fast_q;
    // Any event becomes pending unless a decision point consumes it below.
    pend_c_d = pend_c_q | ev_comida;
    pend_m_d = pend_m_q | ev_medicina;
    // An event is dropped only when its channel already has a request queued.
    ovr_d    = (ev_comida & pend_c_q) | (ev_medicina & pend_m_q);
    decide   = 1'b0;
    req_c    = 1'b0;
    req_m    = 1'b0;
    // fast_q holds the half-period choice sampled when the phase began.
    phase_last = (cnt_q == (fast_q ? LAST_FAST : LAST_NORM));

    case (state_q)
      S_IDLE: decide = 1'b1;
      S_ON: begin
        if (phase_last) begin
          state_d = S_OFF;
          cnt_d   = '0;
          fast_d  = test;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_OFF: begin
        if (phase_last) begin
          if (blk_q == LAST_BLINK) begin
            decide = 1'b1;
          end else begin
            state_d = S_ON;
            cnt_d   = '0;
            fast_d  = test;
            blk_d   = blk_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Decision point: idle, or the last cycle of the final OFF phase.
    // Events arriving now count alongside the pending flags, so nothing
    // arriving on the boundary is lost.
    if (decide) begin
      req_c  = pend_c_q | ev_comida;
      req_m  = pend_m_q | ev_medicina;
      cnt_d  = '0;
      blk_d  = '0;
      fast_d = test;
      if (req_c) begin
        state_d  = S_ON;
        chan_d   = CH_COMIDA;
        pend_c_d = 1'b0;
        pend_m_d = req_m;
      end else if (req_m) begin
        state_d  = S_ON;
        chan_d   = CH_MEDICINA;
        pend_m_d = 1'b0;
      end else begin
        state_d = S_IDLE;
      end
    end

    // Outputs are registered versions of the next state.
    led_c_d = (state_d == S_ON) && (chan_d == CH_COMIDA);
    led_m_d = (state_d == S_ON) && (chan_d == CH_MEDICINA);
    busy_d  = (state_d != S_IDLE);
  end

  assign led_comida   = led_c_q;
  assign led_medicina = led_m_q;
  assign busy         = busy_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_led_feedback.sv
module tb_led_feedback;

  localparam int unsigned HP = 4;
  localparam int unsigned TD = 2;
  localparam int unsigned BL = 2;
  localparam int unsigned HF = ((HP / TD) < 1) ? 1 : (HP / TD);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic test = 1'b0;
  logic ev_comida = 1'b0;
  logic ev_medicina = 1'b0;
  logic led_comida, led_medicina, busy, overrun;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model state: phase-oriented view of one acknowledgement.
  bit m_active;
  int m_chan;      // 0 = comida, 1 = medicina
  int m_phase;     // 0 .. 2*BL-1, even = LED on
  int m_rem;       // cycles left in current phase
  bit m_pc, m_pm;
  bit m_ovr;

  led_feedback #(.HALF_PERIOD(HP), .TEST_DIV(TD), .BLINKS(BL)) dut (
    .clk(clk), .reset(reset), .test(test),
    .ev_comida(ev_comida), .ev_medicina(ev_medicina),
    .led_comida(led_comida), .led_medicina(led_medicina),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

  task automatic apply_reset();
    ev_comida = 1'b0; ev_medicina = 1'b0; test = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_active = 0; m_chan = 0; m_phase = 0; m_rem = 0;
    m_pc = 0; m_pm = 0; m_ovr = 0;
  endtask

  task automatic model_start(input int ch, input int h);
    m_active = 1; m_chan = ch; m_phase = 0; m_rem = h;
  endtask

  task automatic model_step(input bit ec, input bit em, input bit t);
    int h;
    bit dec, rc, rm;
    h = t ? HF : HP;
    m_ovr = (ec && m_pc) || (em && m_pm);
    dec = !m_active;
    if (m_active) begin
      m_rem--;
      if (m_rem == 0) begin
        m_phase++;
        if (m_phase == 2 * BL) dec = 1;
        else m_rem = h;
      end
    end
    if (dec) begin
      rc = m_pc || ec;
      rm = m_pm || em;
      if (rc) begin
        model_start(0, h); m_pc = 0; m_pm = rm;
      end else if (rm) begin
        model_start(1, h); m_pm = 0;
      end else begin
        m_active = 0;
      end
    end else begin
      m_pc = m_pc || ec;
      m_pm = m_pm || em;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if ({led_comida, led_medicina, busy, overrun} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_state got %b exp 0000", {led_comida, led_medicina, busy, overrun});
    end
    // Start a comida sequence, land mid-ON, then reset between edges.
    ev_comida = 1'b1;
    @(posedge clk); #1 ev_comida = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({led_comida, busy} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_pre_on got %b exp 11", {led_comida, busy});
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({led_comida, led_medicina, busy, overrun} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_async got %b exp 0000", {led_comida, led_medicina, busy, overrun});
    end
    @(posedge clk); #1 reset = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      vectors++;
      if ({led_comida, led_medicina, busy, overrun} !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_no_restart n=%0d got %b exp 0000", n, {led_comida, led_medicina, busy, overrun});
      end
    end
  endtask

  task automatic test_single();
    logic [3:0] exp;
    apply_reset();
    for (int n = 0; n <= 30; n++) begin
      ev_comida = (n == 10);
      @(posedge clk); #1;
      exp = {((n+1 >= 11 && n+1 <= 14) || (n+1 >= 19 && n+1 <= 22)), 1'b0,
             (n+1 >= 11 && n+1 <= 26), 1'b0};
      vectors++;
      if ({led_comida, led_medicina, busy, overrun} !== exp) begin
        miscompares++;
        $display("FAIL single c=%0d got %b exp %b", n+1, {led_comida, led_medicina, busy, overrun}, exp);
      end
    end
    ev_comida = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp;
    int c;
    apply_reset();
    for (int n = 0; n <= 46; n++) begin
      ev_comida = (n == 10);
      ev_medicina = (n == 10);
      @(posedge clk); #1;
      c = n + 1;
      exp = {((c >= 11 && c <= 14) || (c >= 19 && c <= 22)),
             ((c >= 27 && c <= 30) || (c >= 35 && c <= 38)),
             (c >= 11 && c <= 42), 1'b0};
      vectors++;
      if ({led_comida, led_medicina, busy, overrun} !== exp) begin
        miscompares++;
        $display("FAIL simultaneous c=%0d got %b exp %b", c, {led_comida, led_medicina, busy, overrun}, exp);
      end
    end
    ev_comida = 1'b0; ev_medicina = 1'b0;
  endtask

  task automatic test_overrun();
    logic [3:0] exp;
    int c;
    apply_reset();
    for (int n = 0; n <= 46; n++) begin
      ev_comida = (n == 10);
      ev_medicina = (n == 13) || (n == 15);
      @(posedge clk); #1;
      c = n + 1;
      exp = {((c >= 11 && c <= 14) || (c >= 19 && c <= 22)),
             ((c >= 27 && c <= 30) || (c >= 35 && c <= 38)),
             (c >= 11 && c <= 42), (c == 16)};
      vectors++;
      if ({led_comida, led_medicina, busy, overrun} !== exp) begin
        miscompares++;
        $display("FAIL overrun c=%0d got %b exp %b", c, {led_comida, led_medicina, busy, overrun}, exp);
      end
    end
    ev_comida = 1'b0; ev_medicina = 1'b0;
  endtask

  task automatic test_fast_mode();
    logic [3:0] exp;
    int c;
    apply_reset();
    test = 1'b1;
    for (int n = 0; n <= 24; n++) begin
      ev_medicina = (n == 10);
      @(posedge clk); #1;
      c = n + 1;
      exp = {1'b0, ((c >= 11 && c <= 12) || (c >= 15 && c <= 16)),
             (c >= 11 && c <= 18), 1'b0};
      vectors++;
      if ({led_comida, led_medicina, busy, overrun} !== exp) begin
        miscompares++;
        $display("FAIL fast_mode c=%0d got %b exp %b", c, {led_comida, led_medicina, busy, overrun}, exp);
      end
    end
    ev_medicina = 1'b0; test = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    int c;
    apply_reset();
    for (int n = 0; n <= 46; n++) begin
      ev_comida = (n == 10) || (n == 26);
      @(posedge clk); #1;
      c = n + 1;
      exp = {((c >= 11 && c <= 14) || (c >= 19 && c <= 22) ||
              (c >= 27 && c <= 30) || (c >= 35 && c <= 38)), 1'b0,
             (c >= 11 && c <= 42), 1'b0};
      vectors++;
      if ({led_comida, led_medicina, busy, overrun} !== exp) begin
        miscompares++;
        $display("FAIL back_to_back c=%0d got %b exp %b", c, {led_comida, led_medicina, busy, overrun}, exp);
      end
    end
    ev_comida = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] exp;
    bit ec, em, t;
    apply_reset();
    t = 0;
    for (int n = 0; n < 1500; n++) begin
      ec = ($urandom_range(0, 15) == 0);
      em = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 39) == 0) t = !t;
      ev_comida = ec; ev_medicina = em; test = t;
      @(posedge clk); #1;
      model_step(ec, em, t);
      exp = {(m_active && m_chan == 0 && (m_phase % 2) == 0),
             (m_active && m_chan == 1 && (m_phase % 2) == 0),
             m_active, m_ovr};
      vectors++;
      if ({led_comida, led_medicina, busy, overrun} !== exp) begin
        miscompares++;
        $display("FAIL random n=%0d got %b exp %b", n, {led_comida, led_medicina, busy, overrun}, exp);
      end
    end
    ev_comida = 1'b0; ev_medicina = 1'b0; test = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_overrun();
    test_fast_mode();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
